// File: rtl/fpaddsub_pkg.sv
// Shared widths and stage payload for the add/sub normalization shifter.
package fpaddsub_pkg;

    // Default single-precision geometry
    localparam int unsigned MAN_W_DEF = 23;
    localparam int unsigned EXP_W_DEF = 8;

    // Unnormalized sum: carry bit, hidden bit, stored fraction
    localparam int unsigned W     = MAN_W_DEF + 2;
    localparam int unsigned LZC_W = $clog2(W + 1);

    // Extended exponent width for signed adjust arithmetic
    localparam int unsigned EXPX_W = EXP_W_DEF + 2;

    // Payload carried between pipeline stages
    typedef struct packed {
        logic [W-1:0]         mant;
        logic [EXP_W_DEF-1:0] exp;
        logic [LZC_W-1:0]     lzc;
        logic                 zero;
        logic                 sticky;
    } stage_t;

endpackage

// File: rtl/fpaddsub_lzc.sv
// Combinational leading-zero counter; count == W means the input is zero.
module fpaddsub_lzc #(
    parameter int unsigned W = 25
) (
    input  logic [W-1:0]             sum,
    output logic [$clog2(W+1)-1:0]   count
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    // Highest set bit wins because later iterations overwrite earlier ones
    always_comb begin
        count = CNT_W'(W);
        for (int i = 0; i < int'(W); i++) begin
            if (sum[i]) begin
                count = CNT_W'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpaddsub_norm_shift.sv
// Post add/sub normalization: 3-stage valid/ready pipeline.
//   S1: leading-zero count of the raw sum
//   S2: coarse left shift (multiple of 4) or 1-bit right shift on carry-out
//   S3: fine left shift (0..3), exponent adjust, zero/underflow/overflow flags
// Optional macro NORM_STICKY_EN: out_sticky reports the bit dropped by the
// carry right shift; when undefined the sticky path is constant 0.
// The stage payload struct is sized from the fpaddsub_pkg defaults.
module fpaddsub_norm_shift
    import fpaddsub_pkg::*;
#(
    parameter int unsigned MAN_W = MAN_W_DEF,
    parameter int unsigned EXP_W = EXP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAN_W+1:0]   in_sum,
    input  logic [EXP_W-1:0]   in_exp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAN_W:0]     out_mant,
    output logic [EXP_W-1:0]   out_exp,
    output logic               out_zero,
    output logic               out_underflow,
    output logic               out_overflow,
    output logic               out_sticky
);

    localparam int unsigned SUM_W    = MAN_W + 2;
    localparam int unsigned LZC_BITS = $clog2(SUM_W + 1);
    localparam int unsigned EXPA_W   = EXP_W + 2;

    // Stage state
    stage_t s1_q, s1_d;
    stage_t s2_q, s2_d;
    logic   s1_v, s2_v, s3_v;

    // Stage load enables: a stage loads when it is empty or draining
    logic en1, en2, en3;

    logic [LZC_BITS-1:0] in_lzc;

    // S3 next-value signals
    logic [MAN_W:0]        s3_mant_d;
    logic [EXP_W-1:0]      s3_exp_d;
    logic                  s3_zero_d;
    logic                  s3_unf_d;
    logic                  s3_ovf_d;
    logic                  s3_sticky_d;

    // Leading-zero count feeding S1
    fpaddsub_lzc #(
        .W (SUM_W)
    ) u_lzc (
        .sum   (in_sum),
        .count (in_lzc)
    );

    // Handshake chain from the output back to the input
    always_comb begin
        en3      = !s3_v || out_ready;
        en2      = !s2_v || en3;
        en1      = !s1_v || en2;
        in_ready = rst && en1;
    end

    // S1 capture payload; sticky only exists when the carry shift drops a bit
    always_comb begin
        s1_d      = '0;
        s1_d.mant = in_sum;
        s1_d.exp  = in_exp;
        s1_d.lzc  = in_lzc;
        s1_d.zero = (in_lzc == LZC_BITS'(SUM_W));
`ifdef NORM_STICKY_EN
        s1_d.sticky = (in_lzc == '0) && in_sum[0];
`else
        s1_d.sticky = 1'b0;
`endif
    end

    // S2 coarse shift: right by 1 on carry-out, else left by (lzc-1) & ~3
    always_comb begin
        logic [LZC_BITS-1:0] shamt;
        logic [LZC_BITS-1:0] coarse;
        shamt  = s1_q.lzc - LZC_BITS'(1);
        coarse = shamt & ~LZC_BITS'(3);
        s2_d   = s1_q;
        if (s1_q.lzc == '0) begin
            s2_d.mant = s1_q.mant >> 1;
        end else begin
            s2_d.mant = s1_q.mant << coarse;
        end
    end

    // S3 fine shift, exponent adjust and result flags
    always_comb begin
        logic [LZC_BITS-1:0] shamt;
        logic [1:0]          fine;
        logic [MAN_W:0]      mant_n;
        logic [EXPA_W-1:0]   exp_adj;
        logic                unf;
        logic                ovf;

        shamt = s2_q.lzc - LZC_BITS'(1);
        fine  = shamt[1:0];
        if (s2_q.lzc == '0) begin
            mant_n = (MAN_W+1)'(s2_q.mant);
        end else begin
            mant_n = (MAN_W+1)'(s2_q.mant << fine);
        end

        // Two extra bits keep the signed result unambiguous: range -W+1..2^EXP_W
        exp_adj = EXPA_W'(s2_q.exp) + EXPA_W'(1) - EXPA_W'(s2_q.lzc);
        unf     = exp_adj[EXPA_W-1] || (exp_adj == '0);
        ovf     = !exp_adj[EXPA_W-1] && (exp_adj >= EXPA_W'({EXP_W{1'b1}}));

        s3_mant_d   = '0;
        s3_exp_d    = '0;
        s3_zero_d   = 1'b0;
        s3_unf_d    = 1'b0;
        s3_ovf_d    = 1'b0;
        s3_sticky_d = s2_q.sticky;

        if (s2_q.zero) begin
            s3_zero_d = 1'b1;
        end else if (unf) begin
            s3_unf_d = 1'b1;
        end else if (ovf) begin
            s3_ovf_d = 1'b1;
            s3_exp_d = {EXP_W{1'b1}};
        end else begin
            s3_mant_d = mant_n;
            s3_exp_d  = exp_adj[EXP_W-1:0];
        end
    end

    // Stage valid bits; reset discards anything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else begin
            if (en1) s1_v <= in_valid;
            if (en2) s2_v <= s1_v;
            if (en3) s3_v <= s2_v;
        end
    end

    // Stage payload registers load only with a valid beat behind them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            if (en1 && in_valid) s1_q <= s1_d;
            if (en2 && s1_v)     s2_q <= s2_d;
        end
    end

    // Output register; holds while the consumer stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_mant      <= '0;
            out_exp       <= '0;
            out_zero      <= 1'b0;
            out_underflow <= 1'b0;
            out_overflow  <= 1'b0;
            out_sticky    <= 1'b0;
        end else if (en3 && s2_v) begin
            out_mant      <= s3_mant_d;
            out_exp       <= s3_exp_d;
            out_zero      <= s3_zero_d;
            out_underflow <= s3_unf_d;
            out_overflow  <= s3_ovf_d;
            out_sticky    <= s3_sticky_d;
        end
    end

    assign out_valid = s3_v;

endmodule

// File: tb/tb_fpaddsub_norm_shift.sv
// Self-checking bench for fpaddsub_norm_shift (MAN_W=23, EXP_W=8).
module tb_fpaddsub_norm_shift;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] in_sum = '0;
    logic [7:0]  in_exp = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_zero, out_underflow, out_overflow, out_sticky;

    typedef struct packed {
        logic [23:0] mant;
        logic [7:0]  exp;
        logic        zero;
        logic        unf;
        logic        ovf;
        logic        sticky;
    } res_t;

    res_t sb[$];
    res_t obs;
    logic acc;
    logic oxf;
    int   n_chk  = 0;
    int   n_pass = 0;

    fpaddsub_norm_shift #(.MAN_W(23), .EXP_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sum        (in_sum),
        .in_exp        (in_exp),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_mant      (out_mant),
        .out_exp       (out_exp),
        .out_zero      (out_zero),
        .out_underflow (out_underflow),
        .out_overflow  (out_overflow),
        .out_sticky    (out_sticky)
    );

    always #5 clk = ~clk;

    // Reference normalization written from the arithmetic definition
    function automatic res_t model(input logic [24:0] s, input logic [7:0] e);
        res_t        r;
        int          lead;
        int          lz;
        int          ea;
        logic [24:0] m;
        r    = '0;
        lead = -1;
        for (int i = 0; i < 25; i++) if (s[i]) lead = i;
        if (lead < 0) begin
            r.zero = 1'b1;
            return r;
        end
        lz = 24 - lead;
        ea = int'(e) + 1 - lz;
        m  = (lz == 0) ? (s >> 1) : (s << (lz - 1));
`ifdef NORM_STICKY_EN
        r.sticky = (lz == 0) && s[0];
`endif
        if (ea < 1) begin
            r.unf = 1'b1;
        end else if (ea >= 255) begin
            r.ovf = 1'b1;
            r.exp = 8'hFF;
        end else begin
            r.mant = m[23:0];
            r.exp  = 8'(ea);
        end
        return r;
    endfunction

    // One cycle: drive at negedge, record both handshakes for the next posedge
    task automatic drive(input logic v, input logic [24:0] s, input logic [7:0] e, input logic r);
        @(negedge clk);
        in_valid  = v;
        in_sum    = s;
        in_exp    = e;
        out_ready = r;
        #1;
        acc = in_valid && in_ready;
        if (acc) sb.push_back(model(s, e));
        oxf = out_valid && out_ready;
        obs = {out_mant, out_exp, out_zero, out_underflow, out_overflow, out_sticky};
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        else n_pass++;
        n_chk++;
        if ({out_mant, out_exp, out_zero, out_underflow, out_overflow, out_sticky} !== '0)
            $display("FAIL reset_data: mant=%h exp=%h flags=%b%b%b%b want 0", out_mant, out_exp, out_zero, out_underflow, out_overflow, out_sticky);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL reset_release: in_ready=%b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_latency();
        res_t ex;
        int   lat;
        lat = -1;
        drive(1'b1, 25'h1800000, 8'h80, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            drive(1'b0, '0, '0, 1'b1);
            if (oxf && lat < 0) begin
                lat = c;
                n_chk++;
                if (sb.size() == 0) $display("FAIL latency_beat: unexpected output beat");
                else begin
                    ex = sb.pop_front();
                    if (obs !== ex) $display("FAIL latency_beat: got %h want %h", obs, ex);
                    else n_pass++;
                end
                n_chk++;
                if (obs !== {24'hC00000, 8'h81, 4'b0000}) $display("FAIL carry_vector: got %h want %h", obs, {24'hC00000, 8'h81, 4'b0000});
                else n_pass++;
            end
        end
        n_chk++;
        if (lat != 3) $display("FAIL latency: got %0d cycles want 3", lat);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [24:0] vs[10] = '{25'h1800000, 25'h0010000, 25'h0800001, 25'h0000000, 25'h0000001,
                                 25'h1000001, 25'h0800000, 25'h1000000, 25'h0800000, 25'h0400000};
        logic [7:0]  ve[10] = '{8'h80, 8'h80, 8'h7F, 8'h55, 8'h10,
                                 8'hFE, 8'h01, 8'hFE, 8'hFE, 8'h01};
        res_t ex;
        int   idx;
        idx = 0;
        for (int c = 0; c < 20 && (idx < 10 || sb.size() != 0); c++) begin
            drive(idx < 10, (idx < 10) ? vs[idx] : 25'h0, (idx < 10) ? ve[idx] : 8'h0, 1'b1);
            if (acc) idx++;
            if (oxf) begin
                n_chk++;
                if (sb.size() == 0) $display("FAIL directed: unexpected output beat %h", obs);
                else begin
                    ex = sb.pop_front();
                    if (obs !== ex) $display("FAIL directed: got %h want %h", obs, ex);
                    else n_pass++;
                end
            end
        end
        n_chk++;
        if (idx != 10 || sb.size() != 0) $display("FAIL directed_drain: sent %0d left %0d want 10 0", idx, sb.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        res_t        ex;
        int          stalls;
        int          idx;
        logic [24:0] s;
        stalls = 0;
        idx    = 0;
        for (int c = 0; c < 40 && (idx < 24 || sb.size() != 0); c++) begin
            s = 25'($urandom) >> $urandom_range(0, 25);
            drive(idx < 24, s, 8'($urandom_range(0, 255)), 1'b1);
            if (idx < 24 && !acc) stalls++;
            if (acc) idx++;
            if (oxf) begin
                n_chk++;
                if (sb.size() == 0) $display("FAIL b2b: unexpected output beat %h", obs);
                else begin
                    ex = sb.pop_front();
                    if (obs !== ex) $display("FAIL b2b: got %h want %h", obs, ex);
                    else n_pass++;
                end
            end
        end
        n_chk++;
        if (stalls != 0 || sb.size() != 0) $display("FAIL b2b_flow: stalls=%0d left=%0d want 0 0", stalls, sb.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [24:0] vs[5] = '{25'h1800000, 25'h0010000, 25'h0800001, 25'h0000000, 25'h1000001};
        logic [7:0]  ve[5] = '{8'h80, 8'h80, 8'h7F, 8'h55, 8'hFE};
        res_t ex;
        res_t held;
        logic have;
        int   idx;
        int   first_c;
        int   last_c;
        int   got;
        have = 1'b0;
        idx  = 0;
        for (int c = 0; c < 6; c++) begin
            drive(idx < 5, (idx < 5) ? vs[idx] : 25'h0, (idx < 5) ? ve[idx] : 8'h0, 1'b0);
            if (acc) idx++;
            if (out_valid) begin
                if (have) begin
                    n_chk++;
                    if (obs !== held) $display("FAIL stall_stable: got %h want %h", obs, held);
                    else n_pass++;
                end
                held = obs;
                have = 1'b1;
            end
        end
        n_chk++;
        if (idx != 3) $display("FAIL stall_accept: accepted %0d want 3", idx);
        else n_pass++;
        n_chk++;
        if (in_ready !== 1'b0) $display("FAIL stall_ready: in_ready=%b want 0", in_ready);
        else n_pass++;
        first_c = -1;
        last_c  = -1;
        got     = 0;
        for (int c = 0; c < 12 && (idx < 5 || sb.size() != 0); c++) begin
            drive(idx < 5, (idx < 5) ? vs[idx] : 25'h0, (idx < 5) ? ve[idx] : 8'h0, 1'b1);
            if (acc) idx++;
            if (oxf) begin
                got++;
                if (first_c < 0) first_c = c;
                last_c = c;
                n_chk++;
                if (sb.size() == 0) $display("FAIL release_order: unexpected output beat %h", obs);
                else begin
                    ex = sb.pop_front();
                    if (obs !== ex) $display("FAIL release_order: got %h want %h", obs, ex);
                    else n_pass++;
                end
            end
        end
        n_chk++;
        if (got != 5 || last_c - first_c != 4) $display("FAIL release_rate: beats=%0d span=%0d want 5 4", got, last_c - first_c);
        else n_pass++;
    endtask

    task automatic test_reset_inflight();
        res_t ex;
        int   lat;
        int   stale;
        drive(1'b1, 25'h0800001, 8'h7F, 1'b0);
        drive(1'b1, 25'h0010000, 8'h80, 1'b0);
        drive(1'b1, 25'h1800000, 8'h80, 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_mant !== '0 || out_exp !== '0)
            $display("FAIL async_reset: out_valid=%b in_ready=%b mant=%h exp=%h want 0 0 0 0", out_valid, in_ready, out_mant, out_exp);
        else n_pass++;
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL post_reset_ready: in_ready=%b want 1", in_ready);
        else n_pass++;
        lat   = -1;
        stale = 0;
        drive(1'b1, 25'h0800000, 8'h40, 1'b1);
        if (oxf) stale++;
        for (int c = 1; c <= 8; c++) begin
            drive(1'b0, '0, '0, 1'b1);
            if (oxf) begin
                if (lat < 0) begin
                    lat = c;
                    n_chk++;
                    if (sb.size() == 0) $display("FAIL post_reset_beat: unexpected output beat");
                    else begin
                        ex = sb.pop_front();
                        if (obs !== ex) $display("FAIL post_reset_beat: got %h want %h", obs, ex);
                        else n_pass++;
                    end
                end else stale++;
            end
        end
        n_chk++;
        if (lat != 3 || stale != 0) $display("FAIL post_reset_flow: latency=%0d stale=%0d want 3 0", lat, stale);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fpaddsub_norm_shift.md
FPADDSUB_NORM_SHIFT -- requirements
Module: fpaddsub_norm_shift

Interface
REQ-001 SHALL have parameter MAN_W, default 23, meaning stored fraction width; input sum width W = MAN_W+2 (bit W-1 carry, bit W-2 hidden).
REQ-002 SHALL have parameter EXP_W, default 8, meaning exponent width.
REQ-003 SHALL have ports, clock and reset first:
 - clk  in  1  single clock, all state on rising edge.
 - rst  in  1  reset, asynchronous assert, active-low.
 - in_valid  in  1  input beat valid.
 - in_ready  out  1  block accepts a beat this cycle.
 - in_sum  in  W  unnormalized add/sub mantissa result.
 - in_exp  in  EXP_W  exponent of the larger operand.
 - out_valid  out  1  output beat valid.
 - out_ready  in  1  downstream accepts.
 - out_mant  out  MAN_W+1  normalized mantissa, hidden bit at MSB.
 - out_exp  out  EXP_W  adjusted exponent.
 - out_zero, out_underflow, out_overflow  out  1 each  result flags.
 - out_sticky  out  1  bit lost on carry right shift (see REQ-016).

Function
REQ-004 SHALL be a 3-stage pipeline: S1 leading-zero count, S2 coarse left shift by lzc-1 rounded down to a multiple of 4, S3 fine left shift by remaining 0..3 bits plus exponent adjust and flags.
REQ-005 lzc SHALL count zeros from bit W-1; range 0..W; lzc=W means zero input.
REQ-006 lzc=0 SHALL right-shift in_sum by 1 and give out_exp = in_exp+1; lzc>=1 SHALL left-shift by lzc-1 and give out_exp = in_exp+1-lzc; vacated bits fill 0.
REQ-007 Exponent arithmetic SHALL be done at EXP_W+2 bits signed before flag checks.
REQ-008 Zero input SHALL give out_zero=1, out_mant=0, out_exp=0, other flags 0.
REQ-009 Adjusted exponent < 1 SHALL give out_underflow=1, out_mant=0, out_exp=0 (flush to zero).
REQ-010 Adjusted exponent >= all-ones SHALL give out_overflow=1, out_exp=all-ones, out_mant=0.
REQ-011 Handshake: transfer on valid&&ready at both ports; in_ready = !S1_valid || S1 advancing; each stage advances when next stage empty or advancing.
REQ-012 Latency SHALL be 3 cycles from input transfer to out_valid with out_ready held high; throughput 1 beat/cycle.
REQ-013 While out_valid && !out_ready, all out_* SHALL hold stable; no beat dropped, duplicated or reordered; max 3 beats in flight.
REQ-014 in_valid SHALL NOT depend combinationally on in_ready; out_valid SHALL NOT depend combinationally on out_ready.

Reset
REQ-015 rst low SHALL immediately clear all stage valids: out_valid=0, in_ready=0 during reset, all out_* data/flags 0; in-flight beats discarded; in_ready=1 first cycle after release.

Configuration
REQ-016 Macro NORM_STICKY_EN defined: out_sticky = in_sum[0] when lzc=0, else 0, carried through pipeline. Undefined: sticky logic absent, out_sticky tied 0.

Structure
REQ-017 Package fpaddsub_pkg SHALL hold MAN_W/EXP_W defaults, W, lzc width ($clog2(W+1)), stage payload struct (mant, exp, lzc, zero, sticky).
REQ-018 Leading-zero count SHALL be a combinational sub-module fpaddsub_lzc instantiated in S1.

Verification (MAN_W=23, EXP_W=8, out_ready=1 unless noted)
REQ-019 in_sum=25'h1800000, in_exp=8'h80 -> 3 cycles later out_mant=24'hC00000, out_exp=8'h81, flags 0.
REQ-020 in_sum=25'h0010000, in_exp=8'h80 -> out_mant=24'h800000, out_exp=8'h79; in_sum=25'h0800001, in_exp=8'h7F -> out_mant=24'h800001, out_exp=8'h7F.
REQ-021 in_sum=0, in_exp=8'h55 -> out_zero=1, out_mant=0, out_exp=0; in_sum=25'h0000001, in_exp=8'h10 -> out_underflow=1, out_mant=0, out_exp=0.
REQ-022 in_sum=25'h1000001, in_exp=8'hFE -> out_overflow=1, out_exp=8'hFF, out_mant=0; with NORM_STICKY_EN out_sticky=1.
REQ-023 out_ready=0 for 6 cycles, 5 back-to-back in_valid beats -> exactly 3 accepted, in_ready low thereafter, outputs stable; on release all beats emerge in order, one per cycle.
REQ-024 rst asserted with 3 beats in flight -> out_valid=0 same cycle; after release no stale beat emerges, next input returns after 3 cycles.
